// File: rtl/id_hazard_scoreboard.sv
`timescale 1ns/1ps
// id_hazard_scoreboard
// Decode-stage scoreboard. Every architectural register (except x0) has an
// entry that records whether a producer is in flight, how many stages it
// has advanced past ID (age), and at which stage its result becomes usable
// (lat). Operands whose producer is not ready yet stall ID. Operands whose
// producer is ready are forwarded from that producer's stage output.
//
// Handshake: id_valid offers the ID instruction and ~stall is the ready.
// The instruction transfers into EX (issue=1) only when
// id_valid & ~stall & ~flush. While stall=1 the offer must be held unchanged.
// Only a transfer writes the scoreboard.
module id_hazard_scoreboard #(
    parameter int XLEN       = 32,
    parameter int NUM_REGS   = 32,
    parameter int IDX_W      = 5,
    parameter int NUM_STAGES = 3,
    parameter int LOAD_LAT   = 2,
    parameter int MUL_LAT    = 3,
    parameter int SEL_W      = 2,
    parameter int CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         id_valid,
    input  logic [IDX_W-1:0]             id_ra_idx,
    input  logic [IDX_W-1:0]             id_rb_idx,
    input  logic                         id_uses_ra,
    input  logic                         id_uses_rb,
    input  logic [IDX_W-1:0]             id_rd_idx,
    input  logic                         id_reg_wr,
    input  logic [1:0]                   id_lat_class,
    input  logic                         flush,
    input  logic [XLEN-1:0]              rf_ra_val,
    input  logic [XLEN-1:0]              rf_rb_val,
    input  logic [XLEN*NUM_STAGES-1:0]   stage_results,
    output logic                         stall,
    output logic                         issue,
    output logic [SEL_W-1:0]             fwd_sel_a,
    output logic [SEL_W-1:0]             fwd_sel_b,
    output logic [XLEN-1:0]              ra_val_out,
    output logic [XLEN-1:0]              rb_val_out,
    output logic [CNT_W-1:0]             stall_cycles
);

    // A multiply whose result appears past the last forwarding stage could
    // never be consumed, so refuse to elaborate such a configuration.
    if (MUL_LAT < 1 || MUL_LAT > NUM_STAGES) begin : g_bad_mul_lat
        $error("id_hazard_scoreboard: MUL_LAT must be in 1..NUM_STAGES");
    end
    if (LOAD_LAT < 1 || LOAD_LAT > NUM_STAGES) begin : g_bad_load_lat
        $error("id_hazard_scoreboard: LOAD_LAT must be in 1..NUM_STAGES");
    end

    localparam logic [SEL_W:0] LAST_AGE = (SEL_W+1)'(NUM_STAGES);

    // Result latency, in stages after ID, for each latency class.
    function automatic logic [SEL_W-1:0] class_lat(input logic [1:0] cls);
        case (cls)
            2'd1:    return SEL_W'(LOAD_LAT);
            2'd2:    return SEL_W'(MUL_LAT);
            default: return SEL_W'(1);  // ALU, and the illegal class
        endcase
    endfunction

    logic [NUM_REGS-1:0] busy;
    logic [SEL_W:0]      age [NUM_REGS];
    logic [SEL_W-1:0]    lat [NUM_REGS];

    logic [SEL_W:0]   age_a, age_b;
    logic [SEL_W-1:0] lat_a, lat_b;
    logic             trk_a, trk_b;
    logic             haz_a, haz_b;
    logic             sb_wr;
    logic [SEL_W-1:0] new_lat;

    assign age_a = age[id_ra_idx];
    assign age_b = age[id_rb_idx];
    assign lat_a = lat[id_ra_idx];
    assign lat_b = lat[id_rb_idx];

    // An operand is tracked when it is read, is not x0 and has a live producer.
    assign trk_a = id_uses_ra & (id_ra_idx != '0) & busy[id_ra_idx];
    assign trk_b = id_uses_rb & (id_rb_idx != '0) & busy[id_rb_idx];

    // Producer not far enough down the pipe to have its result yet.
    assign haz_a = trk_a & (age_a < {1'b0, lat_a});
    assign haz_b = trk_b & (age_b < {1'b0, lat_b});

    assign stall = id_valid & ~flush & (haz_a | haz_b);
    assign issue = id_valid & ~flush & ~stall;

    // Ready producers forward from the stage they currently occupy.
    assign fwd_sel_a = (trk_a & ~haz_a) ? age_a[SEL_W-1:0] : '0;
    assign fwd_sel_b = (trk_b & ~haz_b) ? age_b[SEL_W-1:0] : '0;

    assign sb_wr   = issue & id_reg_wr & (id_rd_idx != '0);
    assign new_lat = class_lat(id_lat_class);

    // Operand muxes: regfile by default, stage k output when select is k.
    always_comb begin
        ra_val_out = rf_ra_val;
        rb_val_out = rf_rb_val;
        for (int k = 1; k <= NUM_STAGES; k++) begin
            if (fwd_sel_a == SEL_W'(k)) ra_val_out = stage_results[(k-1)*XLEN +: XLEN];
            if (fwd_sel_b == SEL_W'(k)) rb_val_out = stage_results[(k-1)*XLEN +: XLEN];
        end
    end

    // Scoreboard update: age live entries, retire after WB, newest producer wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busy[r] <= 1'b0;
                age[r]  <= '0;
                lat[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (sb_wr && (id_rd_idx == IDX_W'(r))) begin
                    busy[r] <= 1'b1;
                    age[r]  <= (SEL_W+1)'(1);
                    lat[r]  <= new_lat;
                end else if (busy[r]) begin
                    if (age[r] >= LAST_AGE) begin
                        // WB has written the regfile; the value is architectural now.
                        busy[r] <= 1'b0;
                        age[r]  <= '0;
                    end else begin
                        age[r] <= age[r] + (SEL_W+1)'(1);
                    end
                end
            end
        end
    end

    // Stall-cycle performance counter, free-running with wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (stall) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
`timescale 1ns/1ps
module tb_id_hazard_scoreboard;

    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 32;
    localparam int IDX_W      = 5;
    localparam int NUM_STAGES = 3;
    localparam int LOAD_LAT   = 2;
    localparam int MUL_LAT    = 3;
    localparam int SEL_W      = 2;
    localparam int CNT_W      = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                       rst;
    logic                       id_valid;
    logic [IDX_W-1:0]           id_ra_idx, id_rb_idx, id_rd_idx;
    logic                       id_uses_ra, id_uses_rb, id_reg_wr;
    logic [1:0]                 id_lat_class;
    logic                       flush;
    logic [XLEN-1:0]            rf_ra_val, rf_rb_val;
    logic [XLEN*NUM_STAGES-1:0] stage_results;
    logic                       stall, issue;
    logic [SEL_W-1:0]           fwd_sel_a, fwd_sel_b;
    logic [XLEN-1:0]            ra_val_out, rb_val_out;
    logic [CNT_W-1:0]           stall_cycles;

    logic [XLEN-1:0] sres [NUM_STAGES];

    always_comb begin
        stage_results = '0;
        for (int k = 0; k < NUM_STAGES; k++) stage_results[k*XLEN +: XLEN] = sres[k];
    end

    id_hazard_scoreboard #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .NUM_STAGES(NUM_STAGES),
        .LOAD_LAT(LOAD_LAT), .MUL_LAT(MUL_LAT), .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_ra_idx(id_ra_idx), .id_rb_idx(id_rb_idx),
        .id_uses_ra(id_uses_ra), .id_uses_rb(id_uses_rb),
        .id_rd_idx(id_rd_idx), .id_reg_wr(id_reg_wr), .id_lat_class(id_lat_class),
        .flush(flush), .rf_ra_val(rf_ra_val), .rf_rb_val(rf_rb_val),
        .stage_results(stage_results),
        .stall(stall), .issue(issue), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
        .ra_val_out(ra_val_out), .rb_val_out(rb_val_out), .stall_cycles(stall_cycles)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Each register remembers the cycle its latest producer issued and its
    // latency. Distance from that cycle gives the producer's stage; the
    // producer is in flight for stages 1..NUM_STAGES.
    int              iss_cyc [NUM_REGS];
    int              mlat    [NUM_REGS];
    int              cyc = 0;
    logic [CNT_W-1:0] exp_cnt;
    logic            rst_req;

    logic             e_stall, e_issue;
    logic [SEL_W-1:0] e_sel_a, e_sel_b;
    logic [XLEN-1:0]  e_ra, e_rb;

    function automatic int class_lat(input logic [1:0] c);
        case (c)
            2'd1:    return LOAD_LAT;
            2'd2:    return MUL_LAT;
            default: return 1;
        endcase
    endfunction

    function automatic int stage_of(input int r);
        return cyc - iss_cyc[r];
    endfunction

    function automatic bit in_flight(input int r);
        return (r != 0) && (iss_cyc[r] >= 0) && (stage_of(r) >= 1) && (stage_of(r) <= NUM_STAGES);
    endfunction

    task automatic model_eval;
        bit ha, hb;
        int sa, sb, ra, rb;
        ha = 0; hb = 0; sa = 0; sb = 0;
        ra = int'(id_ra_idx);
        rb = int'(id_rb_idx);
        if (id_uses_ra && in_flight(ra)) begin
            if (stage_of(ra) < mlat[ra]) ha = 1; else sa = stage_of(ra);
        end
        if (id_uses_rb && in_flight(rb)) begin
            if (stage_of(rb) < mlat[rb]) hb = 1; else sb = stage_of(rb);
        end
        e_stall = id_valid && !flush && (ha || hb);
        e_issue = id_valid && !flush && !e_stall;
        e_sel_a = SEL_W'(sa);
        e_sel_b = SEL_W'(sb);
        e_ra = (sa != 0) ? sres[sa-1] : rf_ra_val;
        e_rb = (sb != 0) ? sres[sb-1] : rf_rb_val;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v,
                         input logic [IDX_W-1:0] a, input logic ua,
                         input logic [IDX_W-1:0] b, input logic ub,
                         input logic [IDX_W-1:0] d, input logic w,
                         input logic [1:0] c, input logic f);
        @(negedge clk);
        rst          = rst_req;
        id_valid     = v;
        id_ra_idx    = a;  id_uses_ra = ua;
        id_rb_idx    = b;  id_uses_rb = ub;
        id_rd_idx    = d;  id_reg_wr  = w;
        id_lat_class = c;
        flush        = f;
        rf_ra_val    = $urandom;
        rf_rb_val    = $urandom;
        for (int k = 0; k < NUM_STAGES; k++) sres[k] = $urandom;
        #1;
        model_eval();
    endtask

    task automatic tick;
        @(posedge clk);
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) iss_cyc[r] = -1;
            exp_cnt = '0;
        end else begin
            if (e_stall) exp_cnt = exp_cnt + CNT_W'(1);
            if (e_issue && id_reg_wr && id_rd_idx != '0) begin
                iss_cyc[id_rd_idx] = cyc;
                mlat[id_rd_idx]    = class_lat(id_lat_class);
            end
        end
        cyc++;
    endtask

    task automatic idle;
        drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic do_reset;
        rst_req = 1'b1;
        idle();
        tick();
        rst_req = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        rst_req = 1'b1;
        idle(); tick();
        idle(); tick();
        rst_req = 1'b0;
        drive(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd0, 1'b0, 2'd0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL reset_issue: got %0b want 1", issue); end
        checks++; if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin errors++; $display("FAIL reset_sel: got %0d/%0d want 0/0", fwd_sel_a, fwd_sel_b); end
        checks++; if (ra_val_out !== rf_ra_val || rb_val_out !== rf_rb_val) begin errors++; $display("FAIL reset_vals: got %h/%h want %h/%h", ra_val_out, rb_val_out, rf_ra_val, rf_rb_val); end
        checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", stall_cycles); end
        tick();
    endtask

    task automatic test_alu_fwd;
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 2'd0, 1'b0);
        checks++; if (issue !== 1'b1) begin errors++; $display("FAIL alu_issue: got %0b want 1", issue); end
        tick();
        drive(1'b1, 5'd5, 1'b1, 5'd1, 1'b1, 5'd9, 1'b1, 2'd0, 1'b0);
        sres[0] = 32'h0000_00AA;
        #1; model_eval();
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %0b want 0", stall); end
        checks++; if (fwd_sel_a !== 2'd1) begin errors++; $display("FAIL alu_sel_a: got %0d want 1", fwd_sel_a); end
        checks++; if (ra_val_out !== 32'h0000_00AA) begin errors++; $display("FAIL alu_val_a: got %h want 000000aa", ra_val_out); end
        tick();
    endtask

    task automatic test_load_use;
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 2'd1, 1'b0);
        tick();
        drive(1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 5'd12, 1'b1, 2'd0, 1'b0);
        checks++; if (stall !== 1'b1 || issue !== 1'b0) begin errors++; $display("FAIL load_stall: got stall=%0b issue=%0b want 1/0", stall, issue); end
        tick();
        drive(1'b1, 5'd2, 1'b1, 5'd6, 1'b1, 5'd12, 1'b1, 2'd0, 1'b0);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_release: got %0b want 0", stall); end
        checks++; if (fwd_sel_b !== 2'd2) begin errors++; $display("FAIL load_sel_b: got %0d want 2", fwd_sel_b); end
        checks++; if (rb_val_out !== sres[1]) begin errors++; $display("FAIL load_val_b: got %h want %h", rb_val_out, sres[1]); end
        checks++; if (stall_cycles !== 32'd1) begin errors++; $display("FAIL load_cnt: got %0d want 1", stall_cycles); end
        tick();
    endtask

    task automatic test_mul;
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 2'd2, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 2'd0, 1'b0);
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mul_stall%0d: got %0b want 1", i, stall); end
            tick();
        end
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 2'd0, 1'b0);
        checks++; if (stall !== 1'b0 || fwd_sel_a !== 2'd3) begin errors++; $display("FAIL mul_wb_fwd: got stall=%0b sel=%0d want 0/3", stall, fwd_sel_a); end
        checks++; if (ra_val_out !== sres[2]) begin errors++; $display("FAIL mul_wb_val: got %h want %h", ra_val_out, sres[2]); end
        checks++; if (stall_cycles !== 32'd2) begin errors++; $display("FAIL mul_cnt: got %0d want 2", stall_cycles); end
        tick();
        drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
        checks++; if (stall !== 1'b0 || fwd_sel_a !== 2'd0 || ra_val_out !== rf_ra_val) begin
            errors++; $display("FAIL mul_retired: got stall=%0b sel=%0d val=%h want 0/0/%h", stall, fwd_sel_a, ra_val_out, rf_ra_val);
        end
        tick();
    endtask

    task automatic test_back_to_back_waw;
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 2'd0, 1'b0);
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8, 1'b1, 2'd1, 1'b0);
        tick();
        drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 2'd0, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %0b want 1", stall); end
        tick();
        drive(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 2'd0, 1'b0);
        checks++; if (stall !== 1'b0 || fwd_sel_a !== 2'd2) begin errors++; $display("FAIL waw_sel: got stall=%0b sel=%0d want 0/2", stall, fwd_sel_a); end
        checks++; if (ra_val_out !== sres[1]) begin errors++; $display("FAIL waw_val: got %h want %h", ra_val_out, sres[1]); end
        tick();
    endtask

    task automatic test_x0;
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 2'd1, 1'b0); tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 2'd2, 1'b0); tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 2'd0, 1'b0); tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 2'd1, 1'b0);
        checks++; if (stall !== 1'b0 || issue !== 1'b1) begin errors++; $display("FAIL x0_stall: got stall=%0b issue=%0b want 0/1", stall, issue); end
        checks++; if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin errors++; $display("FAIL x0_sel: got %0d/%0d want 0/0", fwd_sel_a, fwd_sel_b); end
        checks++; if (ra_val_out !== rf_ra_val || rb_val_out !== rf_rb_val) begin errors++; $display("FAIL x0_vals: got %h/%h want %h/%h", ra_val_out, rb_val_out, rf_ra_val, rf_rb_val); end
        tick();
        drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 2'd0, 1'b0);
        checks++; if (stall !== 1'b0 || fwd_sel_a !== 2'd0) begin errors++; $display("FAIL x0_after_wr: got stall=%0b sel=%0d want 0/0", stall, fwd_sel_a); end
        tick();
    endtask

    task automatic test_flush_and_reset;
        do_reset();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 2'd1, 1'b1);
        checks++; if (issue !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL flush_issue: got issue=%0b stall=%0b want 0/0", issue, stall); end
        tick();
        drive(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 2'd0, 1'b0);
        checks++; if (stall !== 1'b0 || fwd_sel_a !== 2'd0) begin errors++; $display("FAIL flush_no_entry: got stall=%0b sel=%0d want 0/0", stall, fwd_sel_a); end
        tick();
        drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 2'd2, 1'b0);
        tick();
        drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 2'd1, 1'b0);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall: got %0b want 1", stall); end
        tick();
        rst_req = 1'b1;
        drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 2'd1, 1'b0);
        tick();
        rst_req = 1'b0;
        drive(1'b1, 5'd10, 1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 2'd0, 1'b0);
        checks++; if (stall !== 1'b0 || issue !== 1'b1) begin errors++; $display("FAIL rst_clear_stall: got stall=%0b issue=%0b want 0/1", stall, issue); end
        checks++; if (fwd_sel_a !== 2'd0 || fwd_sel_b !== 2'd0) begin errors++; $display("FAIL rst_clear_sel: got %0d/%0d want 0/0", fwd_sel_a, fwd_sel_b); end
        checks++; if (stall_cycles !== '0) begin errors++; $display("FAIL rst_clear_cnt: got %0d want 0", stall_cycles); end
        tick();
    endtask

    task automatic test_random;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst_req = ($urandom_range(0, 99) < 2);
            drive($urandom_range(0, 9) != 0,
                  IDX_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  IDX_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  IDX_W'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0);
            checks++; if (stall !== e_stall) begin errors++; $display("FAIL rnd_stall[%0d]: got %0b want %0b", n, stall, e_stall); end
            checks++; if (issue !== e_issue) begin errors++; $display("FAIL rnd_issue[%0d]: got %0b want %0b", n, issue, e_issue); end
            checks++; if (stall_cycles !== exp_cnt) begin errors++; $display("FAIL rnd_cnt[%0d]: got %0d want %0d", n, stall_cycles, exp_cnt); end
            if (!e_stall) begin
                checks++; if (fwd_sel_a !== e_sel_a || fwd_sel_b !== e_sel_b) begin
                    errors++; $display("FAIL rnd_sel[%0d]: got %0d/%0d want %0d/%0d", n, fwd_sel_a, fwd_sel_b, e_sel_a, e_sel_b);
                end
                checks++; if (ra_val_out !== e_ra || rb_val_out !== e_rb) begin
                    errors++; $display("FAIL rnd_vals[%0d]: got %h/%h want %h/%h", n, ra_val_out, rb_val_out, e_ra, e_rb);
                end
            end
            tick();
        end
        rst_req = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int r = 0; r < NUM_REGS; r++) begin
            iss_cyc[r] = -1;
            mlat[r]    = 1;
        end
        exp_cnt = '0;
        rst_req = 1'b1;
        rst = 1'b1; id_valid = 1'b0; id_ra_idx = '0; id_rb_idx = '0; id_rd_idx = '0;
        id_uses_ra = 1'b0; id_uses_rb = 1'b0; id_reg_wr = 1'b0; id_lat_class = '0;
        flush = 1'b0; rf_ra_val = '0; rf_rb_val = '0;
        for (int k = 0; k < NUM_STAGES; k++) sres[k] = '0;

        test_reset();
        test_alu_fwd();
        test_load_use();
        test_mul();
        test_back_to_back_waw();
        test_x0();
        test_flush_and_reset();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
